// File: rtl/mem_timer_slave.sv
// mem_timer_slave: memory-mapped machine timer on the core's data-RAM bus.
// Holds a free-running 64-bit mtime with a prescaler, a 64-bit compare value,
// control (EN, PERIODIC) and status (PEND, write-1-to-clear) registers.
// Reads are combinational (zero wait states) and writes take effect on the clock edge.
// Writes honour the byte-lane selects.
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   ce_i, we_i    bus chip enable / write enable
//   addr_i        byte address; [31:5] decode, [4:2] register offset
//   sel_i         write byte-lane select
//   data_i        write data
//   data_o        read data, 0 unless this block is read this cycle
//   hit_o         combinational address hit
//   timer_int_o   registered level timer interrupt
module mem_timer_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        hit_o,
  output logic        timer_int_o
);

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4,
    REG_PRESCALE = 3'd5,
    REG_STATUS   = 3'd6,
    REG_RSVD     = 3'd7
  } reg_off_e;

  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q, cmp_d;
  logic                  en_q, en_d;
  logic                  periodic_q, periodic_d;
  logic                  pend_q, pend_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  int_q, int_d;

  reg_off_e              off;
  logic                  wr;
  logic                  tick;
  logic                  cmp_ge;
  logic                  mtime_wr;
  logic [31:0]           prescale_wide;
  logic                  addr_unused;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign hit_o       = ce_i && (addr_i[31:5] == BASE_ADDR[31:5]);
  assign off         = reg_off_e'(addr_i[4:2]);
  assign addr_unused = ^addr_i[1:0];
  assign wr          = hit_o && we_i;
  assign mtime_wr    = wr && (off == REG_MTIME_LO || off == REG_MTIME_HI);
  assign tick        = en_q && (pcnt_q == prescale_q);
  assign cmp_ge      = mtime_q >= cmp_q;
  assign timer_int_o = int_q;

  always_comb begin
    data_o = '0;
    if (hit_o && !we_i) begin
      case (off)
        REG_MTIME_LO: data_o = mtime_q[31:0];
        REG_MTIME_HI: data_o = mtime_q[63:32];
        REG_CMP_LO:   data_o = cmp_q[31:0];
        REG_CMP_HI:   data_o = cmp_q[63:32];
        REG_CTRL:     data_o = {30'd0, periodic_q, en_q};
        REG_PRESCALE: data_o = 32'(prescale_q);
        REG_STATUS:   data_o = {31'd0, pend_q};
        default:      data_o = '0;
      endcase
    end
  end

  always_comb begin
    mtime_d       = mtime_q;
    cmp_d         = cmp_q;
    en_d          = en_q;
    periodic_d    = periodic_q;
    pend_d        = pend_q;
    prescale_d    = prescale_q;
    pcnt_d        = pcnt_q;
    prescale_wide = lane_merge(32'(prescale_q), data_i, sel_i);
    // Interrupt is computed from pre-edge state, giving one cycle of latency.
    int_d         = en_q && (periodic_q ? pend_q : cmp_ge);

    if (wr) begin
      case (off)
        REG_MTIME_LO: mtime_d[31:0]  = lane_merge(mtime_q[31:0], data_i, sel_i);
        REG_MTIME_HI: mtime_d[63:32] = lane_merge(mtime_q[63:32], data_i, sel_i);
        REG_CMP_LO:   cmp_d[31:0]    = lane_merge(cmp_q[31:0], data_i, sel_i);
        REG_CMP_HI:   cmp_d[63:32]   = lane_merge(cmp_q[63:32], data_i, sel_i);
        REG_CTRL: begin
          if (sel_i[0]) begin
            en_d       = data_i[0];
            periodic_d = data_i[1];
            if (!data_i[1]) pend_d = 1'b0;
          end
        end
        REG_PRESCALE: prescale_d = PRESCALE_W'(prescale_wide);
        REG_STATUS: begin
          if (sel_i[0] && data_i[0]) pend_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (mtime_wr || tick) begin
      pcnt_d = '0;
    end else if (en_q) begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end

    // A bus write to mtime pre-empts both the periodic reload and the increment.
    // The PEND set is applied last so it wins over a same-cycle clear.
    if (!mtime_wr && tick) begin
      if (periodic_q && cmp_ge) begin
        mtime_d = '0;
        pend_d  = 1'b1;
      end else begin
        mtime_d = mtime_q + 64'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      cmp_q      <= '1;
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      pend_q     <= 1'b0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      int_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      en_q       <= en_d;
      periodic_q <= periodic_d;
      pend_q     <= pend_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      int_q      <= int_d;
    end
  end

endmodule

// File: tb/tb_mem_timer_slave.sv
`timescale 1ns/1ps
module tb_mem_timer_slave;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk, rst, ce_i, we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic [3:0]  sel_i;
  logic        hit_o, timer_int_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_v, exp_v;

  mem_timer_slave #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i),
    .sel_i(sel_i), .data_i(data_i), .data_o(data_o), .hit_o(hit_o),
    .timer_int_o(timer_int_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] s);
    ce_i = 1'b1; we_i = 1'b1; addr_i = BASE | 32'(off); data_i = d; sel_i = s;
    @(negedge clk);
    ce_i = 1'b0; we_i = 1'b0; data_i = '0; sel_i = '0;
  endtask

  task automatic bus_read(input logic [4:0] off, output logic [31:0] d);
    ce_i = 1'b1; we_i = 1'b0; addr_i = BASE | 32'(off);
    #1;
    d = data_o;
    ce_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rv [8];
    rv = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL reset_int: got %b expected 0", timer_int_o); end
    for (int i = 0; i < 8; i++) exp_q.push_back(rv[i]);
    for (int i = 0; i < 8; i++) begin
      bus_read(5'(i * 4), rd_v);
      exp_v = exp_q.pop_front();
      checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL reset_reg_%0d: got %h expected %h", i, rd_v, exp_v); end
    end
    @(negedge clk);
    // Compare at 0 so the interrupt is high while counting, then reset mid-cycle.
    bus_write(5'h08, 32'h0, 4'hF);
    bus_write(5'h0C, 32'h0, 4'hF);
    bus_write(5'h10, 32'h1, 4'hF);
    idle(20);
    exp_q.push_back(32'd20);
    bus_read(5'h00, rd_v);
    exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL count_before_reset: got %0d expected %0d", rd_v, exp_v); end
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL int_before_reset: got %b expected 1", timer_int_o); end
    rst = 1'b1;
    #1;
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL async_reset_int: got %b expected 0", timer_int_o); end
    idle(2);
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL mtime_after_reset: got %h expected %h", rd_v, exp_v); end
    bus_read(5'h0C, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL cmp_hi_after_reset: got %h expected %h", rd_v, exp_v); end
    bus_read(5'h10, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL ctrl_after_reset: got %h expected %h", rd_v, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_byte_lanes();
    do_reset();
    bus_write(5'h08, 32'hAABB_CCDD, 4'b0101);
    exp_q.push_back(32'hFFBB_FFDD); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'hFFBB_FFDD);
    bus_read(5'h08, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL cmp_lo_lanes: got %h expected %h", rd_v, exp_v); end
    bus_read(5'h0C, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL cmp_hi_untouched: got %h expected %h", rd_v, exp_v); end
    bus_read(5'h0B, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL low_addr_bits_ignored: got %h expected %h", rd_v, exp_v); end
    ce_i = 1'b1; we_i = 1'b0; addr_i = BASE | 32'h08;
    #1;
    checks++; if (hit_o !== 1'b1) begin errors++; $display("FAIL hit_on_access: got %b expected 1", hit_o); end
    // ce_i low: a write to CMP_LO must be ignored.
    ce_i = 1'b0; we_i = 1'b1; data_i = 32'h0; sel_i = 4'hF;
    #1;
    checks++; if (hit_o !== 1'b0 || data_o !== 32'h0) begin errors++; $display("FAIL ce_low_no_hit: got hit %b data %h expected 0 0", hit_o, data_o); end
    @(negedge clk);
    // Address one window above: offset would alias MTIME_LO if decode were wrong.
    ce_i = 1'b1; we_i = 1'b0; addr_i = BASE + 32'h20;
    #1;
    checks++; if (hit_o !== 1'b0 || data_o !== 32'h0) begin errors++; $display("FAIL outside_no_hit: got hit %b data %h expected 0 0", hit_o, data_o); end
    we_i = 1'b1; data_i = 32'h1234_5678;
    @(negedge clk);
    ce_i = 1'b0; we_i = 1'b0; data_i = '0; sel_i = '0;
    bus_write(5'h1C, 32'hFFFF_FFFF, 4'hF);
    exp_q.push_back(32'hFFBB_FFDD); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    bus_read(5'h08, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL cmp_lo_after_ignored: got %h expected %h", rd_v, exp_v); end
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL mtime_after_ignored: got %h expected %h", rd_v, exp_v); end
    bus_read(5'h1C, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL reserved_reads_zero: got %h expected %h", rd_v, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] m_lo, m_hi, d;
    logic [3:0]  s;
    logic        hi;
    m_lo = 32'hFFBB_FFDD; m_hi = 32'hFFFF_FFFF;
    for (int n = 0; n < 8; n++) begin
      d = $urandom; s = 4'($urandom_range(0, 15)); hi = 1'($urandom_range(0, 1));
      bus_write(hi ? 5'h0C : 5'h08, d, s);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) begin
          if (hi) m_hi[8*b +: 8] = d[8*b +: 8];
          else    m_lo[8*b +: 8] = d[8*b +: 8];
        end
      end
      exp_q.push_back(hi ? m_hi : m_lo);
      bus_read(hi ? 5'h0C : 5'h08, rd_v); exp_v = exp_q.pop_front();
      checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL b2b_cmp_%0d: got %h expected %h", n, rd_v, exp_v); end
    end
    @(negedge clk);
  endtask

  task automatic test_prescaler();
    do_reset();
    bus_write(5'h14, 32'd3, 4'hF);
    bus_write(5'h10, 32'd1, 4'hF);
    idle(3);
    exp_q.push_back(32'd0); bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL presc_before_tick: got %0d expected %0d", rd_v, exp_v); end
    idle(1);
    exp_q.push_back(32'd1); bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL presc_first_tick: got %0d expected %0d", rd_v, exp_v); end
    idle(36);
    exp_q.push_back(32'd10); bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL presc_40_clocks: got %0d expected %0d", rd_v, exp_v); end
    bus_write(5'h00, 32'd5, 4'hF);
    exp_q.push_back(32'd5); exp_q.push_back(32'd5); exp_q.push_back(32'd6);
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL mtime_load: got %0d expected %0d", rd_v, exp_v); end
    idle(3);
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL load_hold_3: got %0d expected %0d", rd_v, exp_v); end
    idle(1);
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL load_tick_4: got %0d expected %0d", rd_v, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_compare();
    do_reset();
    bus_write(5'h0C, 32'd0, 4'hF);
    bus_write(5'h08, 32'd100, 4'hF);
    bus_write(5'h00, 32'd98, 4'hF);
    bus_write(5'h10, 32'd1, 4'hF);
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL cmp_int_low_98: got %b expected 0", timer_int_o); end
    idle(2);
    exp_q.push_back(32'd100); bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL cmp_mtime_100: got %0d expected %0d", rd_v, exp_v); end
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL cmp_int_at_100: got %b expected 0", timer_int_o); end
    idle(1);
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL cmp_int_rise: got %b expected 1", timer_int_o); end
    bus_write(5'h08, 32'd200, 4'hF);
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL cmp_int_write_edge: got %b expected 1", timer_int_o); end
    idle(1);
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL cmp_int_fall: got %b expected 0", timer_int_o); end
    bus_write(5'h08, 32'd0, 4'hF);
    idle(1);
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL cmp_int_rearm: got %b expected 1", timer_int_o); end
    bus_write(5'h10, 32'd0, 4'hF);
    idle(1);
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL en_off_int: got %b expected 0", timer_int_o); end
    exp_q.push_back(32'd106); exp_q.push_back(32'd106);
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL en_off_mtime: got %0d expected %0d", rd_v, exp_v); end
    idle(1);
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL en_off_hold: got %0d expected %0d", rd_v, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_periodic_carry();
    do_reset();
    bus_write(5'h00, 32'hFFFF_FFFF, 4'hF);
    bus_write(5'h10, 32'd1, 4'hF);
    bus_write(5'h10, 32'd0, 4'hF);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    bus_read(5'h04, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL carry_hi: got %h expected %h", rd_v, exp_v); end
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL carry_lo: got %h expected %h", rd_v, exp_v); end
    @(negedge clk);

    do_reset();
    bus_write(5'h0C, 32'd0, 4'hF);
    bus_write(5'h08, 32'd4, 4'hF);
    bus_write(5'h10, 32'd3, 4'hF);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'd0);
    for (int i = 0; i < 6; i++) begin
      bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
      checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL periodic_seq_%0d: got %0d expected %0d", i, rd_v, exp_v); end
      if (i < 5) idle(1);
    end
    exp_q.push_back(32'd1); bus_read(5'h18, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL pend_set: got %h expected %h", rd_v, exp_v); end
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL periodic_int_latency: got %b expected 0", timer_int_o); end
    idle(1);
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL periodic_int_rise: got %b expected 1", timer_int_o); end
    // Clear on a non-match cycle (mtime = 1).
    bus_write(5'h18, 32'd1, 4'b0001);
    exp_q.push_back(32'd0); bus_read(5'h18, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL pend_w1c: got %h expected %h", rd_v, exp_v); end
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL w1c_int_latency: got %b expected 1", timer_int_o); end
    idle(1);
    checks++; if (timer_int_o !== 1'b0) begin errors++; $display("FAIL w1c_int_fall: got %b expected 0", timer_int_o); end
    idle(1);
    // This write lands on the edge where mtime = 4 reloads and sets PEND.
    bus_write(5'h18, 32'd1, 4'b0001);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    bus_read(5'h18, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL set_beats_w1c: got %h expected %h", rd_v, exp_v); end
    bus_read(5'h00, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL reload_zero: got %0d expected %0d", rd_v, exp_v); end
    idle(1);
    checks++; if (timer_int_o !== 1'b1) begin errors++; $display("FAIL set_int_rise: got %b expected 1", timer_int_o); end
    bus_write(5'h10, 32'd1, 4'hF);
    exp_q.push_back(32'd0); bus_read(5'h18, rd_v); exp_v = exp_q.pop_front();
    checks++; if (rd_v !== exp_v) begin errors++; $display("FAIL periodic_off_clears_pend: got %h expected %h", rd_v, exp_v); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; sel_i = '0;
    idle(2);
    rst = 1'b0;
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_prescaler();
    test_compare();
    test_periodic_carry();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
